// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader: FSM state encoding and stream framing sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } loader_state_t;

    // Length header is two bytes, LSB first
    localparam int HDR_BYTES  = 2;
    // Instruction words are four bytes, little-endian
    localparam int WORD_BYTES = 4;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_word_packer
// Description : Assembles a little-endian instruction word from a byte
//               stream. Byte j of a word lands in bits [8j+7:8j].
// Revision    : 1.0 - initial release
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   clr        in   synchronous clear of byte index and partial word
//   byte_en    in   accept byte_in this cycle
//   byte_in    in   stream byte
//   word_out   out  assembled word including the byte being accepted
//   word_ready out  high in the cycle whose byte completes a word
// ============================================================================
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    byte_en,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_ready
);

    localparam int c_IDX_W = $clog2(WORD_BYTES);

    logic [c_IDX_W-1:0]      r_idx;
    logic [8*WORD_BYTES-1:0] r_word;
    logic [8*WORD_BYTES-1:0] w_word;

    // Merge the incoming byte combinationally so the parent can register the
    // complete word on the same edge that accepts the final byte.
    always_comb begin
        w_word                = r_word;
        w_word[8*r_idx +: 8]  = byte_in;
    end

    assign word_out   = w_word;
    assign word_ready = byte_en && (r_idx == c_IDX_W'(WORD_BYTES - 1));

    // The index wraps naturally after the last byte; stale bytes of the
    // previous word are all overwritten before the next word_ready.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (byte_en) begin
            r_word <= w_word;
            r_idx  <= r_idx + 1'b1;
        end
    end

endmodule : imem_word_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction memory writer. Receives a 2-byte word
//               count followed by little-endian instruction words, issues one
//               registered write per word and holds the core in reset until
//               the image is complete.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   start      in   pulse that begins a load (ignored while loading)
//   in_valid   in   byte source has data
//   in_data    in   stream byte
//   in_ready   out  loader accepts a byte (decoded from state only)
//   mem_we     out  one-cycle write strobe
//   mem_addr   out  word-aligned byte address
//   mem_wdata  out  instruction word
//   cpu_hold   out  core reset hold; falls one cycle after done rises
//   done       out  image fully written
//   error      out  header count exceeded DEPTH
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int c_WC_W      = $clog2(DEPTH) + 1;
    localparam int c_HDR_IDX_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

    loader_state_t           r_state;
    loader_state_t           w_state_nxt;

    logic [c_HDR_IDX_W-1:0]  r_hdr_idx;
    logic [7:0]              r_count_lo;
    logic [CNT_W-1:0]        r_count;
    logic [c_WC_W-1:0]       r_word_cnt;
    logic                    r_mem_we;
    logic [31:0]             r_mem_addr;
    logic [31:0]             r_mem_wdata;
    logic                    r_cpu_hold;

    logic                    w_accept;
    logic                    w_start_ok;
    logic                    w_hdr_acc;
    logic                    w_hdr_last;
    logic [CNT_W-1:0]        w_count;
    logic                    w_byte_en;
    logic [31:0]             w_word;
    logic                    w_word_ready;
    logic                    w_last_word;

    // ------------------------------------------------------------------
    // Handshake and decode
    // ------------------------------------------------------------------
    assign in_ready   = (r_state == HDR) || (r_state == DATA);
    assign w_accept   = in_valid && in_ready;
    assign w_start_ok = start &&
                        ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));

    assign w_hdr_acc  = w_accept && (r_state == HDR);
    assign w_hdr_last = w_hdr_acc && (r_hdr_idx == c_HDR_IDX_W'(HDR_BYTES - 1));
    assign w_count    = CNT_W'({in_data, r_count_lo});

    assign w_byte_en  = w_accept && (r_state == DATA);
    // The word being completed is index r_word_cnt; it is the last when
    // r_word_cnt + 1 equals the header count.
    assign w_last_word = w_word_ready &&
                         ((32'(r_word_cnt) + 32'd1) == 32'(r_count));

    // ------------------------------------------------------------------
    // Byte-to-word assembly
    // ------------------------------------------------------------------
    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_start_ok),
        .byte_en    (w_byte_en),
        .byte_in    (in_data),
        .word_out   (w_word),
        .word_ready (w_word_ready)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                if (w_hdr_last) begin
                    if (w_count == '0) begin
                        w_state_nxt = DONE;
                    end else if (32'(w_count) > 32'(DEPTH)) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_last_word) begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_idx   <= '0;
            r_count_lo  <= '0;
            r_count     <= '0;
            r_word_cnt  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
        end else begin
            r_mem_we   <= w_word_ready;
            // Hold release trails done by one register stage so the final
            // write has landed before the core's first fetch.
            r_cpu_hold <= (r_state != DONE);

            if (w_start_ok) begin
                r_hdr_idx  <= '0;
                r_word_cnt <= '0;
                r_mem_addr <= '0;
            end

            if (w_hdr_acc) begin
                r_hdr_idx <= r_hdr_idx + 1'b1;
                if (r_hdr_idx == '0) begin
                    r_count_lo <= in_data;
                end
                if (w_hdr_last) begin
                    r_count <= w_count;
                end
            end

            if (w_word_ready) begin
                r_mem_addr  <= {{(32 - c_WC_W - 2){1'b0}}, r_word_cnt, 2'b00};
                r_mem_wdata <= w_word;
                r_word_cnt  <= r_word_cnt + 1'b1;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign done      = (r_state == DONE);
    assign error     = (r_state == ERR);

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. A cycle table covers the
//               basic 2-word load; hand-written sequences cover re-load,
//               gapped input, zero count, oversize header and reset mid-word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    imem_loader #(
        .DEPTH (256),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every strobe cycle is logged with its cycle number
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we === 1'b1) begin
            wq.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
        end
    end

    typedef struct {
        logic        rst;
        logic        start;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        dn;
        logic        er;
        logic        hold;
    } vec_t;

    function automatic vec_t mk(int r, int s, int v, int d, int rdy, int we,
                                int addr, int wd, int dn, int er, int hold);
        vec_t t;
        t.rst   = r[0];
        t.start = s[0];
        t.vld   = v[0];
        t.dat   = d[7:0];
        t.rdy   = rdy[0];
        t.we    = we[0];
        t.addr  = 32'(addr);
        t.wdata = 32'(wd);
        t.dn    = dn[0];
        t.er    = er[0];
        t.hold  = hold[0];
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic we,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic dn, input logic er, input logic hold);
        chk({tag, ".in_ready"},  {31'd0, in_ready}, {31'd0, rdy});
        chk({tag, ".mem_we"},    {31'd0, mem_we},   {31'd0, we});
        chk({tag, ".mem_addr"},  mem_addr,          addr);
        chk({tag, ".mem_wdata"}, mem_wdata,         wd);
        chk({tag, ".done"},      {31'd0, done},     {31'd0, dn});
        chk({tag, ".error"},     {31'd0, error},    {31'd0, er});
        chk({tag, ".cpu_hold"},  {31'd0, cpu_hold}, {31'd0, hold});
    endtask

    // Drive one cycle of inputs, then sample just after the edge
    task automatic step(input logic s, input logic v, input logic [7:0] d);
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[14];
    logic [7:0] img[10];
    int n0;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        img = '{8'h02, 8'h00, 8'h83, 8'h20, 8'h00, 8'h08, 8'h33, 8'h81, 8'h00, 8'h00};

        //           rst st vl dat    rdy we addr wdata        dn er hold
        tbl[0]  = mk(1,  0, 0, 'h00,  0,  0, 0,   0,           0, 0, 1);
        tbl[1]  = mk(0,  1, 0, 'h00,  1,  0, 0,   0,           0, 0, 1);
        tbl[2]  = mk(0,  0, 1, 'h02,  1,  0, 0,   0,           0, 0, 1);
        tbl[3]  = mk(0,  0, 1, 'h00,  1,  0, 0,   0,           0, 0, 1);
        tbl[4]  = mk(0,  0, 1, 'h83,  1,  0, 0,   0,           0, 0, 1);
        tbl[5]  = mk(0,  0, 1, 'h20,  1,  0, 0,   0,           0, 0, 1);
        tbl[6]  = mk(0,  0, 1, 'h00,  1,  0, 0,   0,           0, 0, 1);
        tbl[7]  = mk(0,  0, 1, 'h08,  1,  1, 0,   'h08002083,  0, 0, 1);
        tbl[8]  = mk(0,  0, 1, 'h33,  1,  0, 0,   'h08002083,  0, 0, 1);
        tbl[9]  = mk(0,  0, 1, 'h81,  1,  0, 0,   'h08002083,  0, 0, 1);
        tbl[10] = mk(0,  0, 1, 'h00,  1,  0, 0,   'h08002083,  0, 0, 1);
        tbl[11] = mk(0,  0, 1, 'h00,  0,  1, 4,   'h00008133,  1, 0, 1);
        tbl[12] = mk(0,  0, 0, 'h00,  0,  0, 4,   'h00008133,  1, 0, 0);
        tbl[13] = mk(0,  0, 0, 'h00,  0,  0, 4,   'h00008133,  1, 0, 0);

        // ---------------- 2-word image, one vector per cycle ----------------
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst;
            step(tbl[i].start, tbl[i].vld, tbl[i].dat);
            chk_outs($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].we, tbl[i].addr,
                     tbl[i].wdata, tbl[i].dn, tbl[i].er, tbl[i].hold);
        end
        chk("tbl.nwrites", 32'(wq.size()), 32'd2);

        // ---------------- re-load from DONE with N=1 ----------------
        n0 = wq.size();
        step(1'b1, 1'b0, 8'h00);
        chk_outs("reload.start", 1'b1, 1'b0, 32'h0, 32'h00008133, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h01);
        chk_outs("reload.hdr0", 1'b1, 1'b0, 32'h0, 32'h00008133, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h13);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk_outs("reload.b2", 1'b1, 1'b0, 32'h0, 32'h00008133, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00);
        chk_outs("reload.wr", 1'b0, 1'b1, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        chk_outs("reload.rel", 1'b0, 1'b0, 32'h0, 32'h00000013, 1'b1, 1'b0, 1'b0);
        chk("reload.nwrites", 32'(wq.size() - n0), 32'd1);

        // ---------------- gapped stream ----------------
        n0 = wq.size();
        step(1'b1, 1'b0, 8'h00);
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 1'b1, img[j]);
            if (j < 9) begin
                step(1'b0, 1'b0, 8'hFF);
            end
        end
        chk_outs("gap.last", 1'b0, 1'b1, 32'h4, 32'h00008133, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        chk_outs("gap.rel", 1'b0, 1'b0, 32'h4, 32'h00008133, 1'b1, 1'b0, 1'b0);
        chk("gap.nwrites", 32'(wq.size() - n0), 32'd2);
        if (wq.size() - n0 == 2) begin
            chk("gap.w0.addr", wq[n0].addr, 32'h0);
            chk("gap.w0.data", wq[n0].data, 32'h08002083);
            chk("gap.w1.addr", wq[n0+1].addr, 32'h4);
            chk("gap.w1.data", wq[n0+1].data, 32'h00008133);
            chk("gap.spacing", 32'(wq[n0+1].cyc - wq[n0].cyc), 32'd8);
        end

        // ---------------- zero count ----------------
        n0 = wq.size();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk_outs("zero.done", 1'b0, 1'b0, 32'h0, 32'h00008133, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        chk_outs("zero.rel", 1'b0, 1'b0, 32'h0, 32'h00008133, 1'b1, 1'b0, 1'b0);
        chk("zero.nwrites", 32'(wq.size() - n0), 32'd0);

        // ---------------- oversize header (N=257) ----------------
        n0 = wq.size();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h01);
        chk_outs("over.err", 1'b0, 1'b0, 32'h0, 32'h00008133, 1'b0, 1'b1, 1'b1);
        for (int j = 0; j < 6; j++) begin
            step(1'b0, 1'b1, 8'hAA);
        end
        chk_outs("over.hold", 1'b0, 1'b0, 32'h0, 32'h00008133, 1'b0, 1'b1, 1'b1);
        chk("over.nwrites", 32'(wq.size() - n0), 32'd0);
        step(1'b1, 1'b0, 8'h00);
        chk_outs("over.clr", 1'b1, 1'b0, 32'h0, 32'h00008133, 1'b0, 1'b0, 1'b1);

        // ---------------- reset mid-word, then fresh load ----------------
        n0 = wq.size();
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 1'b1, img[j]);
        end
        chk_outs("rstmid.pre", 1'b1, 1'b0, 32'h0, 32'h08002083, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        chk_outs("rstmid.rst", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h00);
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 1'b1, img[j]);
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk_outs("rstmid.end", 1'b0, 1'b0, 32'h4, 32'h00008133, 1'b1, 1'b0, 1'b0);
        chk("rstmid.nwrites", 32'(wq.size() - n0), 32'd3);
        if (wq.size() - n0 == 3) begin
            chk("rstmid.w0.addr", wq[n0+1].addr, 32'h0);
            chk("rstmid.w0.data", wq[n0+1].data, 32'h08002083);
            chk("rstmid.w1.addr", wq[n0+2].addr, 32'h4);
            chk("rstmid.w1.data", wq[n0+2].data, 32'h00008133);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
